commit_arbiter: RTL and testbench

Parametrised writeback arbiter between the execution units and the register file. It replaces the fixed single-port commit stage. It accepts results from NUM_CH execution channels and writes up to NUM_WP of them per cycle through NUM_WP register-file write ports, selecting fairly with a round-robin pointer. Channels that are not selected get per-channel backpressure. The registered write register numbers also drive the scheduler's register-finished inputs.

---
 rtl/raisin64_pkg.sv | 21 ++
 rtl/rr_pick.sv | 39 +++
 rtl/commit_arbiter.sv | 134 +++++++++++++
 tb/tb_commit_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/raisin64_pkg.sv
// raisin64_pkg: shared pipeline constants and types.
//   RN_W      register-number width
//   DATA_W    result width
//   REG_ZERO  register number meaning "no write"
//   ch_idx_e  execution-channel index used by pipeline wiring
package raisin64_pkg;

   localparam int RN_W   = 6;
   localparam int DATA_W = 64;

   localparam logic [RN_W-1:0] REG_ZERO = '0;

   typedef enum logic [2:0] {
      ALU1    = 3'd0,
      ALU2    = 3'd1,
      ADVINT  = 3'd2,
      MEMUNIT = 3'd3,
      BRANCH  = 3'd4
   } ch_idx_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first set bit of req_i, searching from start_i upward and
// wrapping at NUM_CH-1 back to 0.
//   req_i    request mask, one bit per channel
//   start_i  channel the search begins at (must be < NUM_CH)
//   idx_o    index of the first requesting channel (0 when none found)
//   found_o  1 when any request bit is set
module rr_pick
   import raisin64_pkg::*;
#(
   parameter  int NUM_CH = 5,
   localparam int PTR_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [PTR_W-1:0]  start_i,
   output logic [PTR_W-1:0]  idx_o,
   output logic              found_o
);

   // One extra bit so start + offset cannot overflow before the wrap.
   logic [PTR_W:0] cand;

   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      cand    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = {1'b0, start_i} + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(NUM_CH)) begin
            cand = cand - (PTR_W+1)'(NUM_CH);
         end
         if (!found_o && req_i[cand[PTR_W-1:0]]) begin
            found_o = 1'b1;
            idx_o   = cand[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/commit_arbiter.sv
// commit_arbiter: round-robin writeback arbiter from NUM_CH execution
// channels onto NUM_WP register-file write ports.
//   clk, rst_n  clock, asynchronous active-low reset
//   ch_valid    channel i has a result pending
//   ch_rn       destination register per channel (0 = no write)
//   ch_data     result per channel
//   ch_stall    combinational backpressure: requesting but not granted
//   wr_rn       registered write register per port (0 = port idle)
//   wr_data     registered write data per port
//   rr_ptr      round-robin start channel for the current cycle
// Grant k goes to port k. A channel whose rn matches an earlier grant in
// the same cycle is stalled so one register never gets two writes at once.
// Valid/ready contract: ch_stall=0 with ch_valid=1 means the result is
// taken this cycle; ch_stall=1 means the channel must hold valid/rn/data.
module commit_arbiter
   import raisin64_pkg::*;
#(
   parameter  int NUM_CH = 5,
   parameter  int NUM_WP = 2,
   parameter  int DATA_W = raisin64_pkg::DATA_W,
   parameter  int RN_W   = raisin64_pkg::RN_W,
   localparam int PTR_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*RN_W-1:0]   ch_rn,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_stall,
   output logic [NUM_WP*RN_W-1:0]   wr_rn,
   output logic [NUM_WP*DATA_W-1:0] wr_data,
   output logic [PTR_W-1:0]         rr_ptr
);

   logic [NUM_CH-1:0]        req;
   logic [NUM_CH-1:0]        grant;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic [NUM_WP*RN_W-1:0]   wr_rn_q, wr_rn_d;
   logic [NUM_WP*DATA_W-1:0] wr_data_q, wr_data_d;

   // Per-port results exported from the stage chain; nothing inside the
   // chain reads these, which keeps the chain free of combinational loops.
   logic [NUM_CH-1:0] port_grant [NUM_WP];
   logic              port_found [NUM_WP];
   logic [PTR_W-1:0]  port_idx   [NUM_WP];
   logic [RN_W-1:0]   port_rn    [NUM_WP];
   logic [DATA_W-1:0] port_data  [NUM_WP];

   // rn=0 results are accepted and dropped, so they never request.
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         req[i] = ch_valid[i] && (ch_rn[i*RN_W +: RN_W] != RN_W'(REG_ZERO));
      end
   end

   for (genvar k = 0; k < NUM_WP; k++) begin : g_stage
      logic [NUM_CH-1:0] avail_in;
      logic [NUM_CH-1:0] avail_out;
      logic [NUM_CH-1:0] same_rn;
      logic [PTR_W-1:0]  idx;
      logic              found;
      logic [RN_W-1:0]   sel_rn;

      if (k == 0) begin : g_first
         assign avail_in = req;
      end else begin : g_next
         assign avail_in = g_stage[k-1].avail_out;
      end

      // Every stage starts at rr_ptr; earlier grants are already masked out,
      // so each stage lands on the next requester in walk order.
      rr_pick #(.NUM_CH(NUM_CH)) u_pick (
         .req_i   (avail_in),
         .start_i (ptr_q),
         .idx_o   (idx),
         .found_o (found)
      );

      assign sel_rn = ch_rn[idx*RN_W +: RN_W];

      // Includes the granted channel itself, so one mask removes both the
      // grant and any later channel targeting the same register.
      always_comb begin
         same_rn = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            same_rn[i] = (ch_rn[i*RN_W +: RN_W] == sel_rn);
         end
      end

      assign avail_out     = found ? (avail_in & ~same_rn) : avail_in;
      assign port_grant[k] = found ? (NUM_CH'(1) << idx) : '0;
      assign port_found[k] = found;
      assign port_idx[k]   = idx;
      assign port_rn[k]    = sel_rn;
      assign port_data[k]  = ch_data[idx*DATA_W +: DATA_W];
   end

   always_comb begin
      grant     = '0;
      wr_rn_d   = '0;
      wr_data_d = '0;
      ptr_d     = ptr_q;
      for (int k = 0; k < NUM_WP; k++) begin
         grant = grant | port_grant[k];
         if (port_found[k]) begin
            wr_rn_d[k*RN_W +: RN_W]       = port_rn[k];
            wr_data_d[k*DATA_W +: DATA_W] = port_data[k];
            // Found flags are contiguous from port 0, so the last hit wins.
            ptr_d = (port_idx[k] == PTR_W'(NUM_CH-1)) ? '0
                                                       : port_idx[k] + PTR_W'(1);
         end
      end
   end

   assign ch_stall = req & ~grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_rn_q   <= '0;
         wr_data_q <= '0;
         ptr_q     <= '0;
      end else begin
         wr_rn_q   <= wr_rn_d;
         wr_data_q <= wr_data_d;
         ptr_q     <= ptr_d;
      end
   end

   assign wr_rn   = wr_rn_q;
   assign wr_data = wr_data_q;
   assign rr_ptr  = ptr_q;

endmodule

// File: tb/tb_commit_arbiter.sv
// tb_commit_arbiter: self-checking bench for commit_arbiter (5 channels,
// 2 write ports). Directed vector table, a reset-mid-operation sequence and
// a random phase checked against a behavioural walk model.
module tb_commit_arbiter;

   localparam int NUM_CH = 5;
   localparam int NUM_WP = 2;
   localparam int DATA_W = 64;
   localparam int RN_W   = 6;
   localparam int PTR_W  = 3;
   localparam int W      = NUM_WP*RN_W + NUM_WP*DATA_W + PTR_W;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH*RN_W-1:0]   ch_rn;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [NUM_CH-1:0]        ch_stall;
   logic [NUM_WP*RN_W-1:0]   wr_rn;
   logic [NUM_WP*DATA_W-1:0] wr_data;
   logic [PTR_W-1:0]         rr_ptr;

   always #5 clk = ~clk;

   commit_arbiter #(
      .NUM_CH(NUM_CH), .NUM_WP(NUM_WP), .DATA_W(DATA_W), .RN_W(RN_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ch_valid (ch_valid),
      .ch_rn    (ch_rn),
      .ch_data  (ch_data),
      .ch_stall (ch_stall),
      .wr_rn    (wr_rn),
      .wr_data  (wr_data),
      .rr_ptr   (rr_ptr)
   );

   int checks   = 0;
   int failures = 0;
   logic [W-1:0]     exp_q[$];
   logic [PTR_W-1:0] m_ptr;

   typedef struct {
      logic [NUM_CH-1:0]      valid;
      logic [NUM_CH*RN_W-1:0] rn;
      logic [NUM_CH-1:0]      exp_stall;
      int                     p0;
      int                     p1;
      logic [PTR_W-1:0]       exp_ptr;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [NUM_CH*RN_W-1:0] rn5(input int a0, input int a1, input int a2,
                                                   input int a3, input int a4);
      return {RN_W'(a4), RN_W'(a3), RN_W'(a2), RN_W'(a1), RN_W'(a0)};
   endfunction

   function automatic logic [NUM_CH*DATA_W-1:0] data_tag(input int v);
      logic [NUM_CH*DATA_W-1:0] d;
      for (int c = 0; c < NUM_CH; c++) begin
         d[c*DATA_W +: DATA_W] = 64'hD000_0000_0000_0000 | (64'(v) << 8) | 64'(c);
      end
      return d;
   endfunction

   // Expected outputs from hand-chosen port assignments (channel or -1).
   function automatic logic [W-1:0] build_exp(input logic [NUM_CH*RN_W-1:0] rn,
                                              input logic [NUM_CH*DATA_W-1:0] data,
                                              input int p0, input int p1,
                                              input logic [PTR_W-1:0] ptr);
      logic [NUM_WP*RN_W-1:0]   orn;
      logic [NUM_WP*DATA_W-1:0] odata;
      int p [NUM_WP];
      p[0] = p0; p[1] = p1;
      orn = '0; odata = '0;
      for (int k = 0; k < NUM_WP; k++) begin
         if (p[k] >= 0) begin
            orn[k*RN_W +: RN_W]       = rn[p[k]*RN_W +: RN_W];
            odata[k*DATA_W +: DATA_W] = data[p[k]*DATA_W +: DATA_W];
         end
      end
      return {orn, odata, ptr};
   endfunction

   // Behavioural model: walk from the pointer, grant up to NUM_WP distinct rns.
   task automatic model(input logic [NUM_CH-1:0] valid, input logic [NUM_CH*RN_W-1:0] rn,
                        input logic [NUM_CH*DATA_W-1:0] data,
                        output logic [NUM_CH-1:0] stall, output logic [W-1:0] exp);
      logic [NUM_WP*RN_W-1:0]   orn;
      logic [NUM_WP*DATA_W-1:0] odata;
      logic [RN_W-1:0]          used [NUM_WP];
      logic [RN_W-1:0]          r;
      int cnt, start, c;
      bit conflict;
      orn = '0; odata = '0; stall = '0; cnt = 0;
      start = int'(m_ptr);
      for (int j = 0; j < NUM_CH; j++) begin
         c = (start + j) % NUM_CH;
         r = rn[c*RN_W +: RN_W];
         if (valid[c] && r != 0) begin
            conflict = 0;
            for (int q = 0; q < cnt; q++) if (used[q] == r) conflict = 1;
            if (cnt < NUM_WP && !conflict) begin
               used[cnt] = r;
               orn[cnt*RN_W +: RN_W]       = r;
               odata[cnt*DATA_W +: DATA_W] = data[c*DATA_W +: DATA_W];
               cnt++;
               m_ptr = PTR_W'((c + 1) % NUM_CH);
            end else begin
               stall[c] = 1'b1;
            end
         end
      end
      exp = {orn, odata, m_ptr};
   endtask

   task automatic drive(input logic [NUM_CH-1:0] valid, input logic [NUM_CH*RN_W-1:0] rn,
                        input logic [NUM_CH*DATA_W-1:0] data);
      ch_valid = valid;
      ch_rn    = rn;
      ch_data  = data;
   endtask

   // Called 1 time unit after a rising edge: drive, check stall, push the
   // expected registered result, clock once, pop and compare.
   task automatic step(input string name, input logic [NUM_CH-1:0] valid,
                       input logic [NUM_CH*RN_W-1:0] rn, input logic [NUM_CH*DATA_W-1:0] data,
                       input logic [NUM_CH-1:0] exp_stall, input logic [W-1:0] exp);
      logic [W-1:0] e;
      drive(valid, rn, data);
      #1;
      check({name, "_stall"}, ch_stall, exp_stall);
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({name, "_wr_rn"}, wr_rn, e[PTR_W+NUM_WP*DATA_W +: NUM_WP*RN_W]);
      check({name, "_wr_data"}, wr_data, e[PTR_W +: NUM_WP*DATA_W]);
      check({name, "_rr_ptr"}, rr_ptr, e[PTR_W-1:0]);
   endtask

   initial begin
      logic [NUM_CH-1:0]        st;
      logic [W-1:0]             ex;
      logic [NUM_CH-1:0]        v;
      logic [NUM_CH*RN_W-1:0]   r;
      logic [NUM_CH*DATA_W-1:0] d;

      vecs[0]  = '{5'b00001, rn5(7,0,0,0,0),  5'b00000, 0, -1, 3'd1};
      vecs[1]  = '{5'b10000, rn5(0,0,0,0,3),  5'b00000, 4, -1, 3'd0};
      vecs[2]  = '{5'b11111, rn5(1,2,3,4,5),  5'b11100, 0,  1, 3'd2};
      vecs[3]  = '{5'b11100, rn5(1,2,3,4,5),  5'b10000, 2,  3, 3'd4};
      vecs[4]  = '{5'b10000, rn5(1,2,3,4,5),  5'b00000, 4, -1, 3'd0};
      vecs[5]  = '{5'b01010, rn5(0,9,0,9,0),  5'b01000, 1, -1, 3'd2};
      vecs[6]  = '{5'b01000, rn5(0,9,0,9,0),  5'b00000, 3, -1, 3'd4};
      vecs[7]  = '{5'b10100, rn5(0,0,0,0,12), 5'b00000, 4, -1, 3'd0};
      vecs[8]  = '{5'b01000, rn5(0,0,0,5,0),  5'b00000, 3, -1, 3'd4};
      vecs[9]  = '{5'b10001, rn5(8,0,0,0,6),  5'b00000, 4,  0, 3'd1};
      vecs[10] = '{5'b01111, rn5(2,2,2,4,0),  5'b00101, 1,  3, 3'd4};
      vecs[11] = '{5'b00000, rn5(0,0,0,0,0),  5'b00000, -1, -1, 3'd4};
      vecs[12] = '{5'b10011, rn5(3,3,0,0,0),  5'b00010, 0, -1, 3'd1};
      vecs[13] = '{5'b11111, rn5(0,0,0,0,0),  5'b00000, -1, -1, 3'd1};

      rst_n = 1'b0;
      drive('0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_wr_rn", wr_rn, '0);
      check("reset_wr_data", wr_data, '0);
      check("reset_rr_ptr", rr_ptr, '0);
      rst_n = 1'b1;

      // Directed table; each row relies on the pointer left by the row before.
      for (int i = 0; i < 14; i++) begin
         d = data_tag(i);
         step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].rn, d, vecs[i].exp_stall,
              build_exp(vecs[i].rn, d, vecs[i].p0, vecs[i].p1, vecs[i].exp_ptr));
      end

      // Reset while three channels are stalled, mid-cycle, no edge needed.
      r = rn5(1,2,3,4,5);
      d = data_tag(20);
      step("pre_rst", 5'b11111, r, d, 5'b11001, build_exp(r, d, 1, 2, 3'd3));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_wr_rn", wr_rn, '0);
      check("async_rst_wr_data", wr_data, '0);
      check("async_rst_rr_ptr", rr_ptr, '0);
      check("async_rst_stall", ch_stall, 5'b11100);
      @(posedge clk);
      #1;
      check("held_rst_wr_rn", wr_rn, '0);
      check("held_rst_rr_ptr", rr_ptr, '0);
      rst_n = 1'b1;
      step("post_rst", 5'b11111, r, d, 5'b11100, build_exp(r, d, 0, 1, 3'd2));
      m_ptr = 3'd2;

      // Random phase: small rn range to provoke conflicts and zero dests.
      for (int i = 0; i < 300; i++) begin
         v = NUM_CH'($urandom_range(0, 31));
         for (int c = 0; c < NUM_CH; c++) begin
            r[c*RN_W +: RN_W] = RN_W'($urandom_range(0, 4));
            d[c*DATA_W +: DATA_W] = {$urandom, $urandom};
         end
         model(v, r, d, st, ex);
         step($sformatf("rnd%0d", i), v, r, d, st, ex);
      end

      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
